param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter SHALL be: WIDTH, 16, data bit width.
REQ-002 Parameter SHALL be: DEPTH, 87, number of storage entries (any integer >= 2, power of two not required).
REQ-003 Parameter SHALL be: AF_LEVEL, 80, almost_full asserts when occupancy >= AF_LEVEL.
REQ-004 Parameter SHALL be: AE_LEVEL, 4, almost_empty asserts when occupancy <= AE_LEVEL.
REQ-005 Port SHALL be: clk  input  1  system clock, all logic on rising edge.
REQ-006 Port SHALL be: rst  input  1  reset, synchronous and active-high.
REQ-007 Port SHALL be: wr_en  input  1  write request.
REQ-008 Port SHALL be: buf_in  input  WIDTH  write data.
REQ-009 Port SHALL be: rd_en  input  1  read request.
REQ-010 Port SHALL be: buf_out  output  WIDTH  registered read data.
REQ-011 Port SHALL be: buf_out_valid  output  1  one-cycle pulse, buf_out updated by an accepted read.
REQ-012 Port SHALL be: buf_empty, buf_full, almost_empty, almost_full  output  1 each  status flags.
REQ-013 Port SHALL be: fifo_counter  output  CNT_W  occupancy, CNT_W = clog2(DEPTH+1) (7 at default).
REQ-014 Port SHALL be: overflow, underflow  output  1 each  sticky error flags (present only per REQ-031).

Function
REQ-015 Write SHALL be accepted when wr_en=1 and (buf_full=0 or a read is accepted in the same cycle).
REQ-016 Read SHALL be accepted when rd_en=1 and buf_empty=0; at empty, a simultaneous write is accepted, the read is rejected (no bypass).
REQ-017 Accepted write SHALL store buf_in at wr_ptr; wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-018 Accepted read SHALL load buf_out with entry at rd_ptr on the same edge (latency 1) and pulse buf_out_valid next cycle; rd_ptr increments, wrapping DEPTH-1 -> 0.
REQ-019 Read and write of the same address in one cycle (full, both accepted) SHALL return the old entry on buf_out.
REQ-020 fifo_counter SHALL be +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH.
REQ-021 buf_out SHALL hold its value when no read is accepted.
REQ-022 buf_empty = (fifo_counter==0), buf_full = (fifo_counter==DEPTH), almost flags per REQ-003/004; all decoded from registered fifo_counter.
REQ-023 Rejected requests SHALL change no pointer, counter, memory entry or buf_out.

Reset
REQ-024 On rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, fifo_counter=0, buf_out=0, buf_out_valid=0, overflow=0, underflow=0.
REQ-025 After reset: buf_empty=1, almost_empty=1, buf_full=0, almost_full=0 (AF_LEVEL>0).
REQ-026 rst SHALL take priority over simultaneous wr_en/rd_en; those requests are discarded.
REQ-027 Reset mid-operation SHALL discard all stored entries; memory contents need not be cleared.
REQ-028 Without a clock edge rst SHALL have no effect.

Configuration
REQ-029 Macro FIFO_ERR_FLAG_EN SHALL select error-flag logic.
REQ-030 Defined: overflow sets on wr_en=1 with write rejected; underflow sets on rd_en=1 with buf_empty=1; both clear only on rst.
REQ-031 Undefined: overflow and underflow ports SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, write 0x0001..0x0057 (87 words): buf_full=1, fifo_counter=87, almost_full asserted from 80th write.
REQ-033 From full, one more write of 0xDEAD: rejected, counter stays 87, overflow=1 (macro on); then 87 reads return 0x0001..0x0057 in order, each 1 cycle after rd_en.
REQ-034 At full, simultaneous read+write of 0xBEEF: buf_out=0x0001, counter stays 87, 0xBEEF read last after wrap.
REQ-035 At empty, rd_en=1 with wr_en=1 data 0x1234: buf_out unchanged, buf_out_valid=0, counter=1; next read returns 0x1234.
REQ-036 Write 10 words, assert rst with wr_en=1: next cycle counter=0, buf_empty=1, buf_out=0, overflow/underflow=0.

Source files
------------

// File: rtl/param_fifo_if.sv
// param_fifo handshake/status bundle; FIFO_ERR_FLAG_EN adds sticky error flags.
// slave modport faces the FIFO, master faces the producer/consumer.
interface param_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 87,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             wr_en;
  logic [WIDTH-1:0] buf_in;
  logic             rd_en;
  logic [WIDTH-1:0] buf_out;
  logic             buf_out_valid;
  logic             buf_empty;
  logic             buf_full;
  logic             almost_empty;
  logic             almost_full;
  logic [CNT_W-1:0] fifo_counter;
`ifdef FIFO_ERR_FLAG_EN
  logic             overflow;
  logic             underflow;
`endif

  modport slave (
    input  wr_en, buf_in, rd_en,
    output buf_out, buf_out_valid,
    output buf_empty, buf_full,
    output almost_empty, almost_full,
`ifdef FIFO_ERR_FLAG_EN
    output overflow, underflow,
`endif
    output fifo_counter
  );

  modport master (
    output wr_en, buf_in, rd_en,
    input  buf_out, buf_out_valid,
    input  buf_empty, buf_full,
    input  almost_empty, almost_full,
`ifdef FIFO_ERR_FLAG_EN
    input  overflow, underflow,
`endif
    input  fifo_counter
  );
endinterface

// File: rtl/param_fifo.sv
// Synchronous FIFO, arbitrary DEPTH, registered read data, sync active-high rst.
// Define FIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module param_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 87,
  parameter int AF_LEVEL = 80,
  parameter int AE_LEVEL = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  param_fifo_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_wr_acc;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_W'(DEPTH));
  assign w_rd_acc = bus.rd_en && !w_empty;
  // a read in the same cycle frees the slot a full FIFO needs
  assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc)
      r_mem[r_wr_ptr] <= bus.buf_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_rd_acc;
      if (w_wr_acc)
        r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_rd_acc) begin
        r_out    <= r_mem[r_rd_ptr];
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAG_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.wr_en && !w_wr_acc)
        r_ovf <= 1'b1;
      if (bus.rd_en && w_empty)
        r_udf <= 1'b1;
    end
  end

  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_udf;
`endif

  assign bus.buf_out       = r_out;
  assign bus.buf_out_valid = r_out_valid;
  assign bus.fifo_counter  = r_cnt;
  assign bus.buf_empty     = w_empty;
  assign bus.buf_full      = w_full;
  assign bus.almost_empty  = (r_cnt <= CNT_W'(AE_LEVEL));
  assign bus.almost_full   = (r_cnt >= CNT_W'(AF_LEVEL));
endmodule
